// File: rtl/fpu_pack_stage.sv
// FPU back end: iterative normalisation, round-to-nearest-even and IEEE-754 single packing.
// One transaction in flight; valid/ready on both sides.
module fpu_pack_stage #(
    parameter int unsigned EXP_W  = 10,
    parameter int unsigned MANT_W = 28
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              res_sign_i,
    input  logic [EXP_W-1:0]  res_exp_i,
    input  logic [MANT_W-1:0] res_mant_i,
    input  logic [1:0]        num_status_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       result_o,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic              inexact_o
);

    // num_status encoding shared with the execute stage
    localparam logic [1:0] StatusZero   = 2'd0;
    localparam logic [1:0] StatusNanInf = 2'd1;

    localparam logic [EXP_W-1:0]        ExpMax = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic [EXP_W-1:0]        ExpMin = {1'b1, {(EXP_W-1){1'b0}}};
    localparam logic signed [EXP_W:0]   ExpOvf = 255;

    typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

    state_e              state_q, state_d;
    logic                sign_q, sign_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [MANT_W-1:0]   mant_q, mant_d;
    logic [31:0]         result_q, result_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                inx_q, inx_d;

    logic                inc;
    logic [24:0]         sum;
    logic signed [EXP_W:0] exp_r;
    logic [22:0]         frac_r;

    always_comb begin
        inc    = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
        sum    = {1'b0, mant_q[26:3]} + {24'd0, inc};
        exp_r  = $signed({exp_q[EXP_W-1], exp_q}) + $signed({{EXP_W{1'b0}}, sum[24]});
        // A rounding carry leaves 1.000..., so the renormalised fraction is sum[23:1]
        frac_r = sum[24] ? sum[23:1] : sum[22:0];
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    sign_d = res_sign_i;
                    exp_d  = res_exp_i;
                    mant_d = res_mant_i;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    inx_d  = 1'b0;
                    if (num_status_i == StatusZero) begin
                        result_d = {res_sign_i, 31'b0};
                        state_d  = StDone;
                    end else if (num_status_i == StatusNanInf) begin
                        result_d = (res_mant_i[25:3] == 23'd0) ? {res_sign_i, 8'hFF, 23'b0}
                                                               : 32'h7FC0_0000;
                        state_d  = StDone;
                    end else begin
                        state_d = StNorm;
                    end
                end
            end
            StNorm: begin
                if (mant_q[27]) begin
                    // Shifted-out bit folds into sticky
                    mant_d  = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
                    exp_d   = (exp_q == ExpMax) ? exp_q : exp_q + 1'b1;
                    state_d = StRound;
                end else if (mant_q[26]) begin
                    state_d = StRound;
                end else if (mant_q == '0) begin
                    result_d = {sign_q, 31'b0};
                    state_d  = StDone;
                end else begin
                    mant_d = {mant_q[MANT_W-2:0], 1'b0};
                    exp_d  = (exp_q == ExpMin) ? exp_q : exp_q - 1'b1;
                end
            end
            StRound: begin
                inx_d   = |mant_q[2:0];
                state_d = StDone;
                if (exp_r >= ExpOvf) begin
                    result_d = {sign_q, 8'hFF, 23'b0};
                    ovf_d    = 1'b1;
                    inx_d    = 1'b1;
                end else if (exp_r[EXP_W] || (exp_r == '0)) begin
                    result_d = {sign_q, 31'b0};
                    unf_d    = 1'b1;
                    inx_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_r[7:0], frac_r};
                end
            end
            StDone: begin
                if (out_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign result_o    = result_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
    assign inexact_o   = inx_q;

endmodule

// File: tb/tb_fpu_pack_stage.sv
// Scoreboard bench for fpu_pack_stage: directed cases plus random traffic against an
// arithmetic reference model, with random output backpressure.
module tb_fpu_pack_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        res_sign;
    logic [9:0]  res_exp;
    logic [27:0] res_mant;
    logic [1:0]  num_status;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    fpu_pack_stage #(.EXP_W(10), .MANT_W(28)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .res_sign_i  (res_sign),
        .res_exp_i   (res_exp),
        .res_mant_i  (res_mant),
        .num_status_i(num_status),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .overflow_o  (overflow),
        .underflow_o (underflow),
        .inexact_o   (inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flags;   // {overflow, underflow, inexact}
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stall_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: value = mant * 2^(exp-153), rounded to 24 significant bits, nearest-even.
    function automatic exp_t model(input logic sign, input logic [9:0] ev, input logic [27:0] m,
                                   input logic [1:0] st);
        exp_t   x;
        longint mm, sig, rem, half;
        int     p, e, sh;
        x.flags = 3'b000;
        x.acc   = 0;
        x.res   = 32'h0;
        x.lat   = 1;
        if (st == 2'd0) begin
            x.res = {sign, 31'b0};
        end else if (st == 2'd1) begin
            x.res = (m[25:3] == 23'd0) ? {sign, 8'hFF, 23'b0} : 32'h7FC0_0000;
        end else if (m == 28'd0) begin
            x.res = {sign, 31'b0};
            x.lat = 2;
        end else begin
            p = 0;
            for (int i = 0; i < 28; i++) if (m[i]) p = i;
            x.lat = (p == 27) ? 3 : 3 + (26 - p);
            e  = int'($signed(ev)) + p - 26;
            mm = longint'(m);
            sh = p - 23;
            if (sh > 0) begin
                sig  = mm >> sh;
                rem  = mm & ((longint'(1) << sh) - 1);
                half = longint'(1) << (sh - 1);
            end else begin
                sig  = mm << (-sh);
                rem  = 0;
                half = 1;
            end
            if (rem > half || (rem == half && (sig % 2) == 1)) sig++;
            if (sig == (longint'(1) << 24)) begin
                sig = sig >> 1;
                e++;
            end
            if (e >= 255) begin
                x.res   = {sign, 8'hFF, 23'b0};
                x.flags = 3'b101;
            end else if (e <= 0) begin
                x.res   = {sign, 31'b0};
                x.flags = 3'b011;
            end else begin
                x.res   = {sign, e[7:0], sig[22:0]};
                x.flags = {2'b00, rem != 0};
            end
        end
        return x;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic s, input logic [9:0] e, input logic [27:0] m,
                        input logic [1:0] st, input bit hand, input logic [31:0] hres,
                        input logic [2:0] hfl);
        exp_t x;
        int   t = 0;
        x = model(s, e, m, st);
        if (hand) begin
            x.res   = hres;
            x.flags = hfl;
        end
        res_sign   = s;
        res_exp    = e;
        res_mant   = m;
        num_status = st;
        in_valid   = 1'b1;
        while (!in_ready && t < 300) begin
            step();
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=busy required=ready");
            in_valid = 1'b0;
            return;
        end
        x.acc = cyc;
        sb.push_back(x);
        step();
        in_valid = 1'b0;
    endtask

    // Monitor: drives backpressure, compares on handshake, checks hold-while-stalled and latency
    bit          prev_valid, prev_stall, prev_hs;
    logic [34:0] held;
    always @(negedge clk) begin
        bit   r;
        exp_t x;
        if (!rst_n) begin
            prev_valid = 0;
            prev_stall = 0;
            prev_hs    = 0;
            out_ready  = 1'b0;
        end else begin
            if (prev_hs) check("idle_after_accept", {31'd0, in_ready}, 32'd1);
            if (out_valid) begin
                check("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
                if (!prev_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid actual=valid required=idle");
                    end else begin
                        check("latency", cyc - sb[0].acc, sb[0].lat);
                    end
                end
                if (prev_stall) check("hold_stable", {29'd0, overflow, underflow, inexact} ^
                                      {result[31:29], 29'd0},
                                      {29'd0, held[2:0]} ^ {held[34:32], 29'd0});
                if (prev_stall) check("hold_result", result, held[34:3]);
            end
            r = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (stall_left > 0) stall_left--;
            out_ready = r;
            prev_hs   = out_valid && r;
            if (out_valid && r && sb.size() > 0) begin
                x = sb.pop_front();
                check("result", result, x.res);
                check("flags", {29'd0, overflow, underflow, inexact}, {29'd0, x.flags});
            end
            prev_stall = out_valid && !r;
            prev_valid = out_valid && !r;
            held       = {result, overflow, underflow, inexact};
        end
    end

    initial begin
        int          t;
        logic [27:0] m;
        logic [9:0]  e;
        logic [1:0]  st;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        res_sign   = 1'b0;
        res_exp    = '0;
        res_mant   = '0;
        num_status = 2'd2;
        step();
        step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {29'd0, overflow, underflow, inexact}, 32'd0);
        rst_n = 1'b1;
        step();

        send(0, 10'd127, 28'h6000000, 2'd2, 1, 32'h3FC00000, 3'b000);
        send(0, 10'd127, 28'h8000000, 2'd2, 1, 32'h40000000, 3'b000);
        send(0, 10'd130, 28'h0800000, 2'd2, 1, 32'h3F800000, 3'b000);
        send(0, 10'd127, 28'h400000C, 2'd2, 1, 32'h3F800002, 3'b001);
        send(0, 10'd127, 28'h4000004, 2'd2, 1, 32'h3F800000, 3'b001);
        send(0, 10'd255, 28'h4000000, 2'd2, 1, 32'h7F800000, 3'b101);
        send(0, 10'd0,   28'h4000000, 2'd2, 1, 32'h00000000, 3'b011);
        send(1, 10'd0,   28'h4000000, 2'd2, 1, 32'h80000000, 3'b011);
        stall_left = 6;
        send(0, 10'd0,   28'h0000008, 2'd1, 1, 32'h7FC00000, 3'b000);
        send(1, 10'd0,   28'h0000000, 2'd1, 1, 32'hFF800000, 3'b000);
        send(1, 10'd50,  28'h1234567, 2'd0, 1, 32'h80000000, 3'b000);
        send(0, 10'd140, 28'h0000000, 2'd2, 1, 32'h00000000, 3'b000);

        // Reset while normalising: transaction must vanish
        t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 300) begin
            step();
            t++;
        end
        res_sign = 0; res_exp = 10'd130; res_mant = 28'h0800000; num_status = 2'd2;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_result", result, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        send(0, 10'd127, 28'h6000000, 2'd2, 1, 32'h3FC00000, 3'b000);

        for (int n = 0; n < 300; n++) begin
            st = ($urandom_range(0, 9) == 0) ? 2'd0 : ($urandom_range(0, 9) == 0) ? 2'd1 : 2'd2;
            m  = 28'($urandom) >> $urandom_range(0, 27);
            if ($urandom_range(0, 3) == 0) m = {m[27:3], 3'b100};
            if ($urandom_range(0, 20) == 0) m = 28'd0;
            case ($urandom_range(0, 3))
                0:       e = 10'($urandom);
                1:       e = 10'($urandom_range(0, 8));
                2:       e = 10'($urandom_range(248, 262));
                default: e = 10'($urandom_range(100, 160));
            endcase
            send(1'($urandom), e, m, st, 0, 32'd0, 3'b000);
        end

        t = 0;
        while (sb.size() != 0 && t < 500) begin
            step();
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        end
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
